// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM states, default width and counter sizing for the serial adder
package serial_adder_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full-adder cell shared by the serial adder controller
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder around one full_adder cell
// SERIAL_ADDER_SUB_EN adds the sub port (A - B via ~B and carry-in 1)
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] a_q, b_q, b_ld;
  logic [CW-1:0] cnt;
  logic carry, c_ld, s_bit, c_bit, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~op_b : op_b;
  assign c_ld = sub | cin;
`else
  assign b_ld = op_b;
  assign c_ld = cin;
`endif
  assign last = cnt == CW'(WIDTH - 1);
  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .c(carry), .sum(s_bit), .carry(c_bit));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  // result fills from the top so the LSB lands in bit 0 after WIDTH shifts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      a_q   <= op_a;
      b_q   <= b_ld;
      carry <= c_ld;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum   <= {s_bit, sum[WIDTH-1:1]};
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      carry <= c_bit;
      cnt   <= last ? cnt : cnt + 1'b1;
      if (last) cout <= c_bit;
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
